// File: rtl/fir_tap_window.sv
// Serial-to-parallel sample window feeding the FIR stage, with optional decimation.
// Optional zero-prefill start-up windows: define FIR_TAP_WINDOW_ZERO_PREFILL_EN.
module fir_tap_window #(
   parameter int unsigned TAPS  = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned DECIM = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [DW-1:0] s_data,
   output logic          win_valid,
   input  logic          win_ready,
   output logic [DW-1:0] win_data [TAPS],
   output logic          primed
);

   localparam int unsigned CW = $clog2(TAPS + 1);
   localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [CW-1:0] FILL_FULL = CW'(TAPS);
   localparam logic [CW-1:0] FILL_LAST = CW'(TAPS - 1);
   localparam logic [PW-1:0] PHASE_MAX = PW'(DECIM - 1);

   logic [CW-1:0] fill;
   logic [CW-1:0] fill_nxt;
   logic [PW-1:0] phase;
   logic [PW-1:0] phase_nxt;
   logic          accept;
   logic          advance;
   logic          emit;

   // Consumer-side stall: no new sample while an unconsumed window is held.
   assign s_ready = !rst && !flush && (!win_valid || win_ready);

   // Fill/phase bookkeeping; the phase only runs once emission is possible.
   always_comb begin
      accept   = s_valid && s_ready;
      fill_nxt = fill;
      if (accept && (fill != FILL_FULL)) begin
         fill_nxt = fill + CW'(1);
      end
`ifdef FIR_TAP_WINDOW_ZERO_PREFILL_EN
      advance = accept;
`else
      advance = accept && (fill >= FILL_LAST);
`endif
      emit      = advance && (phase == '0);
      phase_nxt = phase;
      if (advance) begin
         phase_nxt = (phase == PHASE_MAX) ? '0 : phase + PW'(1);
      end
   end

   // Window shift register, counters and output strobes; flush clears like reset.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int k = 0; k < int'(TAPS); k++) begin
            win_data[k] <= '0;
         end
         fill      <= '0;
         phase     <= '0;
         primed    <= 1'b0;
         win_valid <= 1'b0;
      end else begin
         if (accept) begin
            for (int k = int'(TAPS) - 1; k > 0; k--) begin
               win_data[k] <= win_data[k-1];
            end
            win_data[0] <= s_data;
         end
         fill   <= fill_nxt;
         phase  <= phase_nxt;
         primed <= (fill_nxt == FILL_FULL);
         if (emit) begin
            win_valid <= 1'b1;
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end

endmodule
